// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge: arbitrates instruction read, data read and data write
// requests from the core onto one byte-enabled synchronous RAM port.
// Ports:
//   clk, rst_n                           clock, async active-low reset
//   i_read_*, d_read_*, d_write_*        request pulses with size/address/data
//   read_valid/read_data/read_src        read response to the core
//   write_finish, misalign               write done / misaligned-grant pulses
//   mem_re/mem_we/mem_adr/mem_be/...     RAM port
module cpu_mem_bridge #(
   parameter int AW     = 16,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_read_req,
   input  logic          i_read_w,
   input  logic          i_read_hw,
   input  logic [31:0]   i_read_adr,
   input  logic          d_read_req,
   input  logic          d_read_w,
   input  logic          d_read_hw,
   input  logic [31:0]   d_read_adr,
   input  logic          d_write_req,
   input  logic          d_write_w,
   input  logic          d_write_hw,
   input  logic [31:0]   d_write_adr,
   input  logic [31:0]   d_write_data,
   output logic          read_valid,
   output logic [31:0]   read_data,
   output logic          read_src,
   output logic          write_finish,
   output logic          misalign,
   output logic          mem_re,
   output logic          mem_we,
   output logic [AW-3:0] mem_adr,
   output logic [3:0]    mem_be,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [1:0] S_WR   = 2'd3;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   function automatic logic [1:0] size_of(input logic w, input logic hw);
      if (w)
         return SZ_W;
      else if (hw)
         return SZ_H;
      else
         return SZ_B;
   endfunction

   logic          unused_adr;
   assign unused_adr = ^{i_read_adr[31:AW], d_read_adr[31:AW],
                         d_write_adr[31:AW]};

   logic [1:0]    state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;

   logic          ir_pend_q, ir_pend_d;
   logic [AW-1:0] ir_adr_q, ir_adr_d;
   logic [1:0]    ir_sz_q, ir_sz_d;
   logic          dr_pend_q, dr_pend_d;
   logic [AW-1:0] dr_adr_q, dr_adr_d;
   logic [1:0]    dr_sz_q, dr_sz_d;
   logic          dw_pend_q, dw_pend_d;
   logic [AW-1:0] dw_adr_q, dw_adr_d;
   logic [1:0]    dw_sz_q, dw_sz_d;
   logic [31:0]   dw_data_q, dw_data_d;

   logic          cur_src_q, cur_src_d;
   logic [1:0]    cur_a_q, cur_a_d;
   logic [1:0]    cur_sz_q, cur_sz_d;
   logic [AW-3:0] mem_adr_q, mem_adr_d;
   logic [31:0]   read_data_q, read_data_d;
   logic          read_src_q, read_src_d;

   logic          idle;
   logic          gnt_ir, gnt_dr, gnt_dw;
   logic          g_any, g_rd, g_src;
   logic [AW-1:0] g_adr;
   logic [1:0]    g_sz, g_a;
   logic [31:0]   g_dat, g_lanes, lane_rdata;
   logic [3:0]    g_be;
   logic          ir_cap, dr_cap, dw_cap;

   // Fixed priority: write, then data read, then instruction read.
   assign idle   = (state_q == S_IDLE);
   assign gnt_dw = idle && dw_pend_q;
   assign gnt_dr = idle && dr_pend_q && !dw_pend_q;
   assign gnt_ir = idle && ir_pend_q && !dr_pend_q && !dw_pend_q;

   always_comb begin
      g_any = 1'b0;
      g_rd  = 1'b0;
      g_src = 1'b0;
      g_adr = '0;
      g_sz  = SZ_B;
      g_dat = '0;
      unique case (1'b1)
         gnt_dw: begin
            g_any = 1'b1;
            g_adr = dw_adr_q;
            g_sz  = dw_sz_q;
            g_dat = dw_data_q;
         end
         gnt_dr: begin
            g_any = 1'b1;
            g_rd  = 1'b1;
            g_src = 1'b1;
            g_adr = dr_adr_q;
            g_sz  = dr_sz_q;
         end
         gnt_ir: begin
            g_any = 1'b1;
            g_rd  = 1'b1;
            g_adr = ir_adr_q;
            g_sz  = ir_sz_q;
         end
         default: ;
      endcase
   end

   assign g_a = g_adr[1:0];

   always_comb begin
      g_be    = 4'hF;
      g_lanes = g_dat;
      unique case (g_sz)
         SZ_B: begin
            g_be    = 4'b0001 << g_a;
            g_lanes = {4{g_dat[7:0]}};
         end
         SZ_H: begin
            g_be    = g_a[1] ? 4'b1100 : 4'b0011;
            g_lanes = {2{g_dat[15:0]}};
         end
         default: ;
      endcase
   end

   // Misaligned accesses still run; the low address bits are simply
   // dropped on the word-addressed RAM port.
   assign misalign  = g_any && (((g_sz == SZ_H) && g_a[0]) ||
                                ((g_sz == SZ_W) && (g_a != 2'b00)));
   assign mem_re    = g_any && g_rd;
   assign mem_we    = g_any && !g_rd;
   assign mem_be    = g_any ? g_be : 4'h0;
   assign mem_wdata = mem_we ? g_lanes : 32'h0;
   assign mem_adr   = mem_adr_d;

   always_comb begin
      lane_rdata = mem_rdata;
      unique case (cur_sz_q)
         SZ_B: lane_rdata = {24'h0, mem_rdata[{cur_a_q, 3'b000} +: 8]};
         SZ_H: lane_rdata = cur_a_q[1] ? {16'h0, mem_rdata[31:16]}
                                       : {16'h0, mem_rdata[15:0]};
         default: ;
      endcase
   end

   // A request in its own grant cycle is re-captured; otherwise a request
   // to an already-pending source is dropped.
   assign ir_cap = i_read_req  && (!ir_pend_q || gnt_ir);
   assign dr_cap = d_read_req  && (!dr_pend_q || gnt_dr);
   assign dw_cap = d_write_req && (!dw_pend_q || gnt_dw);

   always_comb begin
      ir_pend_d = ir_cap || (ir_pend_q && !gnt_ir);
      ir_adr_d  = ir_cap ? i_read_adr[AW-1:0] : ir_adr_q;
      ir_sz_d   = ir_cap ? size_of(i_read_w, i_read_hw) : ir_sz_q;
      dr_pend_d = dr_cap || (dr_pend_q && !gnt_dr);
      dr_adr_d  = dr_cap ? d_read_adr[AW-1:0] : dr_adr_q;
      dr_sz_d   = dr_cap ? size_of(d_read_w, d_read_hw) : dr_sz_q;
      dw_pend_d = dw_cap || (dw_pend_q && !gnt_dw);
      dw_adr_d  = dw_cap ? d_write_adr[AW-1:0] : dw_adr_q;
      dw_sz_d   = dw_cap ? size_of(d_write_w, d_write_hw) : dw_sz_q;
      dw_data_d = dw_cap ? d_write_data : dw_data_q;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cur_src_d   = cur_src_q;
      cur_a_d     = cur_a_q;
      cur_sz_d    = cur_sz_q;
      mem_adr_d   = g_any ? g_adr[AW-1:2] : mem_adr_q;
      read_data_d = read_data_q;
      read_src_d  = read_src_q;
      unique case (state_q)
         S_IDLE: begin
            if (g_any && g_rd) begin
               state_d   = S_RD;
               cnt_d     = 3'(RD_LAT);
               cur_src_d = g_src;
               cur_a_d   = g_a;
               cur_sz_d  = g_sz;
            end else if (g_any) begin
               state_d = S_WR;
            end
         end
         S_RD: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_d == 3'd0) begin
               read_data_d = lane_rdata;
               read_src_d  = cur_src_q;
               state_d     = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign read_valid   = (state_q == S_RESP);
   assign write_finish = (state_q == S_WR);
   assign read_data    = read_data_q;
   assign read_src     = read_src_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         ir_pend_q   <= 1'b0;
         ir_adr_q    <= '0;
         ir_sz_q     <= '0;
         dr_pend_q   <= 1'b0;
         dr_adr_q    <= '0;
         dr_sz_q     <= '0;
         dw_pend_q   <= 1'b0;
         dw_adr_q    <= '0;
         dw_sz_q     <= '0;
         dw_data_q   <= '0;
         cur_src_q   <= 1'b0;
         cur_a_q     <= '0;
         cur_sz_q    <= '0;
         mem_adr_q   <= '0;
         read_data_q <= '0;
         read_src_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ir_pend_q   <= ir_pend_d;
         ir_adr_q    <= ir_adr_d;
         ir_sz_q     <= ir_sz_d;
         dr_pend_q   <= dr_pend_d;
         dr_adr_q    <= dr_adr_d;
         dr_sz_q     <= dr_sz_d;
         dw_pend_q   <= dw_pend_d;
         dw_adr_q    <= dw_adr_d;
         dw_sz_q     <= dw_sz_d;
         dw_data_q   <= dw_data_d;
         cur_src_q   <= cur_src_d;
         cur_a_q     <= cur_a_d;
         cur_sz_q    <= cur_sz_d;
         mem_adr_q   <= mem_adr_d;
         read_data_q <= read_data_d;
         read_src_q  <= read_src_d;
      end
   end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Bench for cpu_mem_bridge: two instances (read latency 1 and 3) share
// stimulus; a transaction-level model is compared every cycle.
module tb_cpu_mem_bridge;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_req = 0, i_w = 0, i_hw = 0;
   logic [31:0] i_adr = 0;
   logic        dr_req = 0, dr_w = 0, dr_hw = 0;
   logic [31:0] dr_adr = 0;
   logic        dw_req = 0, dw_w = 0, dw_hw = 0;
   logic [31:0] dw_adr = 0, dw_dat = 0;

   logic [1:0]        rv, rsrc, wf, mis, re, we;
   logic [1:0][31:0]  rdat, wdat, mrd;
   logic [1:0][3:0]   be;
   logic [1:0][13:0]  madr;

   logic        pl_we = 0;
   logic [13:0] pl_adr = 0;
   logic [31:0] pl_dat = 0;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int ncyc    = 0;

   always #5 clk = ~clk;

   cpu_mem_bridge #(.AW(16), .RD_LAT(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .i_read_req(i_req), .i_read_w(i_w), .i_read_hw(i_hw),
      .i_read_adr(i_adr),
      .d_read_req(dr_req), .d_read_w(dr_w), .d_read_hw(dr_hw),
      .d_read_adr(dr_adr),
      .d_write_req(dw_req), .d_write_w(dw_w), .d_write_hw(dw_hw),
      .d_write_adr(dw_adr), .d_write_data(dw_dat),
      .read_valid(rv[0]), .read_data(rdat[0]), .read_src(rsrc[0]),
      .write_finish(wf[0]), .misalign(mis[0]),
      .mem_re(re[0]), .mem_we(we[0]), .mem_adr(madr[0]),
      .mem_be(be[0]), .mem_wdata(wdat[0]), .mem_rdata(mrd[0]));

   cpu_mem_bridge #(.AW(16), .RD_LAT(3)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .i_read_req(i_req), .i_read_w(i_w), .i_read_hw(i_hw),
      .i_read_adr(i_adr),
      .d_read_req(dr_req), .d_read_w(dr_w), .d_read_hw(dr_hw),
      .d_read_adr(dr_adr),
      .d_write_req(dw_req), .d_write_w(dw_w), .d_write_hw(dw_hw),
      .d_write_adr(dw_adr), .d_write_data(dw_dat),
      .read_valid(rv[1]), .read_data(rdat[1]), .read_src(rsrc[1]),
      .write_finish(wf[1]), .misalign(mis[1]),
      .mem_re(re[1]), .mem_we(we[1]), .mem_adr(madr[1]),
      .mem_be(be[1]), .mem_wdata(wdat[1]), .mem_rdata(mrd[1]));

   // RAM models; read data emerges RD_LAT cycles after the strobe.
   logic [31:0] ram  [2][16384];
   logic [31:0] pipe [2][4];

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] nw,
                                         input logic [3:0]  en);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (en[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (pl_we)
            ram[k][pl_adr] <= pl_dat;
         else if (we[k])
            ram[k][madr[k]] <= merge(ram[k][madr[k]], wdat[k], be[k]);
         pipe[k][0] <= re[k] ? ram[k][madr[k]] : 32'hBAD0BAD0;
         for (int i = 1; i < 4; i++)
            pipe[k][i] <= pipe[k][i-1];
      end
   end

   assign mrd[0] = pipe[0][0];
   assign mrd[1] = pipe[1][2];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int k,
                      input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d] got %h want %h (cycle %0d)",
                  nm, k, act, exp, cyc);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // Sources: 0 = instruction read, 1 = data read, 2 = data write.
   // Sizes:   0 = byte, 1 = halfword, 2 = word.
   logic [31:0] mm [2][16384];
   bit          pend [2][3];
   logic [15:0] padr [2][3];
   logic [1:0]  psz  [2][3];
   logic [31:0] pdat [2];
   int          free_at [2];
   int          resp_at [2];
   int          fin_at  [2];
   logic [31:0] resp_val [2];
   logic        resp_src [2];
   logic [31:0] h_rd  [2];
   logic        h_src [2];
   logic [13:0] h_adr [2];

   function automatic logic [1:0] sz_of(input logic w, input logic hw);
      return w ? 2'd2 : (hw ? 2'd1 : 2'd0);
   endfunction

   task automatic model_step(input int k);
      logic        e_re, e_we, e_mis, e_rv, e_wf;
      logic [3:0]  e_be;
      logic [31:0] e_wd, w, d;
      logic [15:0] ga;
      logic [1:0]  a, sz;
      int          s, lat;
      lat   = (k == 0) ? 1 : 3;
      e_re  = 0; e_we = 0; e_mis = 0; e_rv = 0; e_wf = 0;
      e_be  = 0; e_wd = 0;
      if (!rst_n) begin
         for (int j = 0; j < 3; j++) begin
            pend[k][j] = 0; padr[k][j] = 0; psz[k][j] = 0;
         end
         pdat[k] = 0; free_at[k] = 0; resp_at[k] = -1; fin_at[k] = -1;
         h_rd[k] = 0; h_src[k] = 0; h_adr[k] = 0;
      end else begin
         s = -1;
         if (pend[k][2]) s = 2;
         else if (pend[k][1]) s = 1;
         else if (pend[k][0]) s = 0;
         if (s >= 0 && ncyc >= free_at[k]) begin
            ga = padr[k][s];
            a  = ga[1:0];
            sz = psz[k][s];
            pend[k][s] = 0;
            h_adr[k] = ga[15:2];
            e_mis = (sz == 1 && a[0]) || (sz == 2 && a != 0);
            e_be  = (sz == 0) ? (4'b0001 << a) :
                    (sz == 1) ? (a[1] ? 4'b1100 : 4'b0011) : 4'hF;
            w = mm[k][ga[15:2]];
            if (s == 2) begin
               d = pdat[k];
               e_we = 1;
               if (sz == 0) begin
                  e_wd = {4{d[7:0]}};
                  w[8*a +: 8] = d[7:0];
               end else if (sz == 1) begin
                  e_wd = {2{d[15:0]}};
                  w[16*a[1] +: 16] = d[15:0];
               end else begin
                  e_wd = d;
                  w = d;
               end
               mm[k][ga[15:2]] = w;
               fin_at[k]  = ncyc + 1;
               free_at[k] = ncyc + 2;
            end else begin
               e_re = 1;
               resp_src[k] = (s == 1);
               if (sz == 0)      resp_val[k] = (w >> (8*a)) & 32'hFF;
               else if (sz == 1) resp_val[k] = (w >> (16*a[1])) & 32'hFFFF;
               else              resp_val[k] = w;
               resp_at[k] = ncyc + 1 + lat;
               free_at[k] = ncyc + 2 + lat;
            end
         end
         if (ncyc == resp_at[k]) begin
            e_rv = 1;
            h_rd[k]  = resp_val[k];
            h_src[k] = resp_src[k];
         end
         e_wf = (ncyc == fin_at[k]);
      end
      chk("read_valid",   k, 32'(rv[k]),   32'(e_rv));
      chk("write_finish", k, 32'(wf[k]),   32'(e_wf));
      chk("misalign",     k, 32'(mis[k]),  32'(e_mis));
      chk("mem_re",       k, 32'(re[k]),   32'(e_re));
      chk("mem_we",       k, 32'(we[k]),   32'(e_we));
      chk("mem_be",       k, 32'(be[k]),   32'(e_be));
      chk("mem_wdata",    k, wdat[k],      e_wd);
      chk("mem_adr",      k, 32'(madr[k]), 32'(h_adr[k]));
      chk("read_data",    k, rdat[k],      h_rd[k]);
      chk("read_src",     k, 32'(rsrc[k]), 32'(h_src[k]));
      if (rst_n) begin
         if (i_req && !pend[k][0]) begin
            pend[k][0] = 1; padr[k][0] = i_adr[15:0];
            psz[k][0] = sz_of(i_w, i_hw);
         end
         if (dr_req && !pend[k][1]) begin
            pend[k][1] = 1; padr[k][1] = dr_adr[15:0];
            psz[k][1] = sz_of(dr_w, dr_hw);
         end
         if (dw_req && !pend[k][2]) begin
            pend[k][2] = 1; padr[k][2] = dw_adr[15:0];
            psz[k][2] = sz_of(dw_w, dw_hw); pdat[k] = dw_dat;
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (pl_we) begin
            mm[0][pl_adr] = pl_dat;
            mm[1][pl_adr] = pl_dat;
         end
         model_step(0);
         model_step(1);
         ncyc++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      i_req = 0; dr_req = 0; dw_req = 0;
   endtask

   task automatic preload(input logic [13:0] a, input logic [31:0] v);
      pl_we = 1; pl_adr = a; pl_dat = v;
      tick();
      pl_we = 0;
   endtask

   task automatic wait_rv(input int k, output int at,
                          output logic [31:0] d, output logic s);
      bit ok;
      ok = 0; at = -1; d = 0; s = 0;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk);
         if (rv[k]) begin
            ok = 1; at = cyc; d = rdat[k]; s = rsrc[k];
         end
      end
      chk("rv_timeout", k, 32'(ok), 32'd1);
   endtask

   task automatic count_d(input int ncy, output int c0, output int c1,
                          output logic [31:0] l0, output logic [31:0] l1);
      c0 = 0; c1 = 0; l0 = 0; l1 = 0;
      for (int i = 0; i < ncy; i++) begin
         @(negedge clk);
         if (rv[0] && rsrc[0]) begin c0++; l0 = rdat[0]; end
         if (rv[1] && rsrc[1]) begin c1++; l1 = rdat[1]; end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------- directed vectors ----------------
   initial begin
      int t, at, c0, c1;
      logic [31:0] d, l0, l1;
      logic s;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_rdata", k, rdat[k], 32'h0);
         chk("rst_madr",  k, 32'(madr[k]), 32'h0);
      end
      rst_n = 1;
      preload(14'h40, 32'hDEADBEEF);
      preload(14'h50, 32'h11223344);
      preload(14'h60, 32'h55667788);
      preload(14'h80, 32'h1234ABCD);

      // instruction word read
      i_req = 1; i_w = 1; i_hw = 0; i_adr = 32'h0000_0100;
      t = cyc; tick(); clr();
      chk("ir_grant_re",  0, 32'(re[0]), 32'd1);
      chk("ir_grant_adr", 0, 32'(madr[0]), 32'h40);
      wait_rv(0, at, d, s);
      chk("ir_lat1", 0, 32'(at - t), 32'd3);
      chk("ir_data", 0, d, 32'hDEADBEEF);
      chk("ir_src",  0, 32'(s), 32'd0);
      wait_rv(1, at, d, s);
      chk("ir_lat3", 1, 32'(at - t), 32'd5);
      chk("ir_data", 1, d, 32'hDEADBEEF);
      tick();

      // byte write then byte read back
      dw_req = 1; dw_w = 0; dw_hw = 0; dw_adr = 32'h103; dw_dat = 32'hA5;
      tick(); clr();
      chk("bw_be",    0, 32'(be[0]), 32'h8);
      chk("bw_wdata", 0, wdat[0], 32'hA5A5A5A5);
      tick();
      chk("bw_finish", 0, 32'(wf[0]), 32'd1);
      chk("bw_finish", 1, 32'(wf[1]), 32'd1);
      dr_req = 1; dr_w = 0; dr_hw = 0; dr_adr = 32'h103;
      tick(); clr();
      wait_rv(0, at, d, s);
      chk("br_data", 0, d, 32'hA5);
      chk("br_src",  0, 32'(s), 32'd1);
      wait_rv(1, at, d, s);
      chk("br_data", 1, d, 32'hA5);
      tick();

      // three simultaneous requests
      i_req = 1; i_w = 1; i_adr = 32'h180;
      dr_req = 1; dr_w = 1; dr_adr = 32'h140;
      dw_req = 1; dw_w = 1; dw_adr = 32'h180; dw_dat = 32'hCAFEF00D;
      t = cyc; tick(); clr();
      chk("arb_we_first", 0, 32'(we[0]), 32'd1);
      wait_rv(0, at, d, s);
      chk("arb_dr_at",   0, 32'(at - t), 32'd5);
      chk("arb_dr_src",  0, 32'(s), 32'd1);
      chk("arb_dr_data", 0, d, 32'h11223344);
      wait_rv(0, at, d, s);
      chk("arb_ir_at",   0, 32'(at - t), 32'd8);
      chk("arb_ir_src",  0, 32'(s), 32'd0);
      chk("arb_ir_data", 0, d, 32'hCAFEF00D);
      wait_rv(1, at, d, s);
      chk("arb_ir_at",   1, 32'(at - t), 32'd12);
      chk("arb_ir_src",  1, 32'(s), 32'd0);
      tick();

      // halfword reads, aligned and misaligned
      dr_req = 1; dr_w = 0; dr_hw = 1; dr_adr = 32'h202;
      tick(); clr();
      wait_rv(0, at, d, s);
      chk("hr_hi", 0, d, 32'h00001234);
      wait_rv(1, at, d, s);
      chk("hr_hi", 1, d, 32'h00001234);
      tick();
      dr_req = 1; dr_w = 0; dr_hw = 1; dr_adr = 32'h201;
      tick(); clr();
      chk("hr_mis", 0, 32'(mis[0]), 32'd1);
      chk("hr_mis", 1, 32'(mis[1]), 32'd1);
      wait_rv(0, at, d, s);
      chk("hr_lo", 0, d, 32'h0000ABCD);
      wait_rv(1, at, d, s);
      tick();

      // halfword write, then read with w and hw both set
      dw_req = 1; dw_w = 0; dw_hw = 1; dw_adr = 32'h202; dw_dat = 32'hBEEF;
      tick(); clr();
      chk("hw_be",    0, 32'(be[0]), 32'hC);
      chk("hw_wdata", 0, wdat[0], 32'hBEEFBEEF);
      tick();
      dr_req = 1; dr_w = 1; dr_hw = 1; dr_adr = 32'h200;
      tick(); clr();
      wait_rv(0, at, d, s);
      chk("w_wins", 0, d, 32'hBEEFABCD);
      wait_rv(1, at, d, s);
      chk("w_wins", 1, d, 32'hBEEFABCD);
      tick();

      // second request to an already-pending source is dropped
      i_req = 1; i_w = 1; i_hw = 0; i_adr = 32'h100;
      tick(); clr();
      dr_req = 1; dr_w = 1; dr_hw = 0; dr_adr = 32'h200;
      tick(); clr();
      dr_req = 1; dr_adr = 32'h140;
      tick(); clr();
      count_d(20, c0, c1, l0, l1);
      chk("ign_cnt",  0, 32'(c0), 32'd1);
      chk("ign_cnt",  1, 32'(c1), 32'd1);
      chk("ign_data", 1, l1, 32'hBEEFABCD);
      tick();

      // request in the grant cycle of the same source is kept
      dr_req = 1; dr_w = 1; dr_hw = 0; dr_adr = 32'h200;
      tick(); clr();
      dr_req = 1; dr_adr = 32'h140;
      tick(); clr();
      count_d(20, c0, c1, l0, l1);
      chk("set_wins_cnt",  0, 32'(c0), 32'd2);
      chk("set_wins_cnt",  1, 32'(c1), 32'd2);
      chk("set_wins_data", 0, l0, 32'h11223344);
      tick();

      // reset in the middle of a read
      dr_req = 1; dr_w = 1; dr_hw = 0; dr_adr = 32'h100;
      tick(); clr();
      tick();
      #2 rst_n = 0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_out", k, {rv[k], wf[k], mis[k], re[k], we[k], be[k],
                            rsrc[k]}, 32'h0);
         chk("rst_out_rdata", k, rdat[k], 32'h0);
         chk("rst_out_wdata", k, wdat[k], 32'h0);
         chk("rst_out_madr",  k, 32'(madr[k]), 32'h0);
      end
      @(posedge clk);
      #1 rst_n = 1;
      count_d(10, c0, c1, l0, l1);
      chk("rst_drop", 0, 32'(c0), 32'd0);
      chk("rst_drop", 1, 32'(c1), 32'd0);
      tick();
      i_req = 1; i_w = 1; i_hw = 0; i_adr = 32'h100;
      t = cyc; tick(); clr();
      wait_rv(0, at, d, s);
      chk("post_rst_lat",  0, 32'(at - t), 32'd3);
      chk("post_rst_data", 0, d, 32'hA5ADBEEF);
      wait_rv(1, at, d, s);
      chk("post_rst_data", 1, d, 32'hA5ADBEEF);
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
